// File: rtl/multi_bit_synchronizer_pkg.sv
// Shared constants and helpers for the multi-channel synchronizer.
package sync_pkg;

  localparam int SYNC_MIN_STAGES = 2;
  localparam int SYNC_MIN_FILTER = 1;

  function automatic int sync_cnt_width(input int filter_cycles);
    return (filter_cycles < 1) ? 1 : $clog2(filter_cycles + 1);
  endfunction

endpackage

// File: rtl/multi_bit_synchronizer_if.sv
// Level/pulse bundle between asynchronous sources and the synchronized domain.
interface multi_bit_synchronizer_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] bits_in;
  logic [WIDTH-1:0] bits_out;
  logic [WIDTH-1:0] rise_out;
  logic [WIDTH-1:0] fall_out;
  logic             changed_out;

  modport master (
    output bits_in,
    input  bits_out,
    input  rise_out,
    input  fall_out,
    input  changed_out
  );

  modport slave (
    input  bits_in,
    output bits_out,
    output rise_out,
    output fall_out,
    output changed_out
  );

endinterface

// File: rtl/multi_bit_synchronizer_channel.sv
// One synchronizer channel: metastability chain, optional stability filter
// (SYNC_FILTER_EN), registered level and rise/fall pulses.
module sync_channel
  import sync_pkg::*;
#(
  parameter int   STAGES        = 3,
  parameter logic INIT          = 1'b0,
  parameter int   FILTER_CYCLES = 4
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic i_bit,
  output logic o_bit,
  output logic o_rise,
  output logic o_fall,
  output logic o_edge_next
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_chain;
  logic w_sync;
  logic w_bit_next;
  logic r_bit;
  logic r_rise;
  logic r_fall;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_chain <= {STAGES{INIT}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_bit};
    end
  end

  assign w_sync = r_chain[STAGES-1];

`ifdef SYNC_FILTER_EN
  localparam int CW = sync_cnt_width(FILTER_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;

  // Output follows only after FILTER_CYCLES consecutive differing samples.
  always_comb begin
    w_bit_next = r_bit;
    w_cnt_next = '0;
    if (w_sync != r_bit) begin
      if (r_cnt == CNT_LAST) begin
        w_bit_next = w_sync;
      end else begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end
`else
  logic w_unused_filter;

  assign w_unused_filter = |FILTER_CYCLES;
  assign w_bit_next      = w_sync;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_bit  <= INIT;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_bit  <= w_bit_next;
      r_rise <= w_bit_next & ~r_bit;
      r_fall <= ~w_bit_next & r_bit;
    end
  end

  assign o_bit       = r_bit;
  assign o_rise      = r_rise;
  assign o_fall      = r_fall;
  assign o_edge_next = w_bit_next ^ r_bit;

endmodule

// File: rtl/multi_bit_synchronizer.sv
// Multi-channel synchronizer for independent quasi-static bits; the stability
// filter is built only when SYNC_FILTER_EN is defined.
module multi_bit_synchronizer
  import sync_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter int               STAGES        = 3,
  parameter logic [WIDTH-1:0] INITIALIZE    = '0,
  parameter int               FILTER_CYCLES = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  multi_bit_synchronizer_if.slave  sync_bus
);

  if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
    $error("multi_bit_synchronizer: STAGES must be at least %0d", SYNC_MIN_STAGES);
  end

`ifdef SYNC_FILTER_EN
  if (FILTER_CYCLES < SYNC_MIN_FILTER) begin : g_bad_filter
    $error("multi_bit_synchronizer: FILTER_CYCLES must be at least %0d", SYNC_MIN_FILTER);
  end
`endif

  logic [WIDTH-1:0] w_bits_out;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_edge_next;
  logic             r_changed;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
    sync_channel #(
      .STAGES        (STAGES),
      .INIT          (INITIALIZE[gi]),
      .FILTER_CYCLES (FILTER_CYCLES)
    ) u_ch (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .i_bit       (sync_bus.bits_in[gi]),
      .o_bit       (w_bits_out[gi]),
      .o_rise      (w_rise[gi]),
      .o_fall      (w_fall[gi]),
      .o_edge_next (w_edge_next[gi])
    );
  end

  // Built from next-state edges so it lines up with the per-channel pulses.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_changed <= 1'b0;
    end else begin
      r_changed <= |w_edge_next;
    end
  end

  assign sync_bus.bits_out    = w_bits_out;
  assign sync_bus.rise_out    = w_rise;
  assign sync_bus.fall_out    = w_fall;
  assign sync_bus.changed_out = r_changed;

endmodule

// File: tb/tb_multi_bit_synchronizer.sv
// Directed bench for multi_bit_synchronizer with a cycle-level reference model.
module tb_multi_bit_synchronizer;

  localparam int         W             = 8;
  localparam int         STAGES        = 3;
  localparam int         FILTER_CYCLES = 4;
  localparam logic [7:0] INIT          = 8'hA5;
`ifdef SYNC_FILTER_EN
  localparam int F_EFF = FILTER_CYCLES;
`else
  localparam int F_EFF = 1;
`endif
  localparam int LAT  = STAGES + F_EFF;
  localparam int MIDC = (F_EFF - 1 < 2) ? F_EFF - 1 : 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  multi_bit_synchronizer_if #(.WIDTH(W)) sbus ();

  multi_bit_synchronizer #(
    .WIDTH         (W),
    .STAGES        (STAGES),
    .INITIALIZE    (INIT),
    .FILTER_CYCLES (FILTER_CYCLES)
  ) dut (
    .clk_in   (clk),
    .rst_in   (rst),
    .sync_bus (sbus)
  );

  // Reference: input delay line of STAGES samples, then a run-length rule.
  logic [W-1:0] m_hist[$];
  logic [W-1:0] m_out, m_rise, m_fall;
  logic         m_chg;
  int           m_run[W];

  always @(posedge clk or posedge rst) begin
    logic [W-1:0] sync_pre;
    logic [W-1:0] nxt;
    if (rst) begin
      m_hist = {};
      for (int s = 0; s < STAGES; s++) m_hist.push_back(INIT);
      m_out  = INIT;
      m_rise = '0;
      m_fall = '0;
      m_chg  = 1'b0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
    end else begin
      sync_pre = m_hist[STAGES-1];
      m_hist.push_front(sbus.bits_in);
      void'(m_hist.pop_back());
      nxt = m_out;
      for (int i = 0; i < W; i++) begin
        if (sync_pre[i] != m_out[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] >= F_EFF) begin
            nxt[i]   = sync_pre[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_rise = nxt & ~m_out;
      m_fall = ~nxt & m_out;
      m_chg  = |(nxt ^ m_out);
      m_out  = nxt;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_mdl_out"},  32'(sbus.bits_out),    32'(m_out));
    chk({tag, "_mdl_rise"}, 32'(sbus.rise_out),    32'(m_rise));
    chk({tag, "_mdl_fall"}, 32'(sbus.fall_out),    32'(m_fall));
    chk({tag, "_mdl_chg"},  32'(sbus.changed_out), 32'(m_chg));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    chk_model(tag);
  endtask

  initial begin
    sbus.bits_in = 8'h00;
    rst = 1'b1;
    tick("rst");
    tick("rst");
    chk("rst_out",  32'(sbus.bits_out), 32'hA5);
    chk("rst_rise", 32'(sbus.rise_out), 32'h0);
    chk("rst_fall", 32'(sbus.fall_out), 32'h0);
    chk("rst_chg",  32'(sbus.changed_out), 32'h0);
    $display("txn reset: bits_out=%h", sbus.bits_out);

    rst = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick("rel");
      chk("rel_out",  32'(sbus.bits_out), (k >= LAT) ? 32'h00 : 32'hA5);
      chk("rel_fall", 32'(sbus.fall_out), (k == LAT) ? 32'hA5 : 32'h00);
      chk("rel_rise", 32'(sbus.rise_out), 32'h0);
    end
    $display("txn release: bits_out=%h", sbus.bits_out);

    sbus.bits_in = 8'h01;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick("lat");
      chk("lat_out0",  32'(sbus.bits_out[0]), (k >= LAT) ? 32'd1 : 32'd0);
      chk("lat_rise0", 32'(sbus.rise_out[0]), (k == LAT) ? 32'd1 : 32'd0);
      chk("lat_chg",   32'(sbus.changed_out), (k == LAT) ? 32'd1 : 32'd0);
    end
    $display("txn latency: bits_out=%h after %0d edges", sbus.bits_out, LAT);

    sbus.bits_in = 8'h00;
    repeat (LAT + 2) tick("settle");

    sbus.bits_in[2] = 1'b1;
    repeat (F_EFF - 1) tick("glitch");
    sbus.bits_in[2] = 1'b0;
    for (int k = 1; k <= LAT + F_EFF; k++) begin
      tick("glitch");
      chk("glitch_out", 32'(sbus.bits_out), 32'h00);
      chk("glitch_chg", 32'(sbus.changed_out), 32'h0);
    end
    $display("txn glitch width %0d: bits_out=%h", F_EFF - 1, sbus.bits_out);

    sbus.bits_in[2] = 1'b1;
    for (int k = 1; k <= LAT + F_EFF + 1; k++) begin
      tick("pulse");
      if (k == F_EFF) sbus.bits_in[2] = 1'b0;
      chk("pulse_out2",  32'(sbus.bits_out[2]), (k >= LAT && k < LAT + F_EFF) ? 32'd1 : 32'd0);
      chk("pulse_rise2", 32'(sbus.rise_out[2]), (k == LAT) ? 32'd1 : 32'd0);
      chk("pulse_fall2", 32'(sbus.fall_out[2]), (k == LAT + F_EFF) ? 32'd1 : 32'd0);
    end
    $display("txn pulse width %0d: bits_out=%h", F_EFF, sbus.bits_out);

    sbus.bits_in = 8'hFF;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick("simul");
      chk("simul_rise", 32'(sbus.rise_out), (k == LAT) ? 32'hFF : 32'h00);
      chk("simul_chg",  32'(sbus.changed_out), (k == LAT) ? 32'd1 : 32'd0);
    end
    $display("txn simultaneous: bits_out=%h", sbus.bits_out);

    sbus.bits_in = 8'hFD;
    repeat (STAGES + MIDC) tick("mid");
    chk("mid_pre_out", 32'(sbus.bits_out), 32'hFF);
    rst = 1'b1;
    #1;
    chk_model("midrst");
    chk("midrst_out",  32'(sbus.bits_out), 32'hA5);
    chk("midrst_rise", 32'(sbus.rise_out), 32'h0);
    chk("midrst_fall", 32'(sbus.fall_out), 32'h0);
    chk("midrst_chg",  32'(sbus.changed_out), 32'h0);
    tick("midrst");
    tick("midrst");
    rst = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick("rerel");
      chk("rerel_out",  32'(sbus.bits_out), (k >= LAT) ? 32'hFD : 32'hA5);
      chk("rerel_rise", 32'(sbus.rise_out), (k == LAT) ? 32'h58 : 32'h00);
      chk("rerel_fall", 32'(sbus.fall_out), 32'h0);
    end
    $display("txn mid reset: bits_out=%h", sbus.bits_out);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
